sw_seq_feeder: RTL

//  Upstream stage of the SW array. Accepts one job (64 ref + 48 query symbols) from a stalling host stream.

---
 rtl/sw_seq_feeder_pkg.sv | 36 +++
 rtl/sw_seq_feeder_if.sv | 53 +++++
 rtl/sw_seq_feeder_decode.sv | 39 +++
 rtl/sw_seq_feeder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sw_seq_feeder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sw_pkg
//  Description : Shared base codes, ASCII symbols, feeder state encoding and
//                default job lengths for the SW sequence feeder.
//  Revision    : 1.0 - initial release
// ============================================================================
package sw_pkg;

    // 2-bit base codes as consumed by the SW array
    localparam logic [1:0] c_BASE_A = 2'd0;
    localparam logic [1:0] c_BASE_C = 2'd1;
    localparam logic [1:0] c_BASE_G = 2'd2;
    localparam logic [1:0] c_BASE_T = 2'd3;

    localparam logic [7:0] c_ASCII_A_UP = 8'h41;
    localparam logic [7:0] c_ASCII_C_UP = 8'h43;
    localparam logic [7:0] c_ASCII_G_UP = 8'h47;
    localparam logic [7:0] c_ASCII_T_UP = 8'h54;
    localparam logic [7:0] c_ASCII_A_LO = 8'h61;
    localparam logic [7:0] c_ASCII_C_LO = 8'h63;
    localparam logic [7:0] c_ASCII_G_LO = 8'h67;
    localparam logic [7:0] c_ASCII_T_LO = 8'h74;

    localparam int c_LEN_REF   = 64;
    localparam int c_LEN_QUERY = 48;

    typedef enum logic [1:0] {
        ST_LOAD     = 2'd0,
        ST_BURST    = 2'd1,
        ST_WAIT_FIN = 2'd2,
        ST_RESULT   = 2'd3
    } feed_state_t;

endpackage : sw_pkg
`default_nettype wire

// File: rtl/sw_seq_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module      : sw_seq_feeder_if
//  Description : Host symbol stream, SW array link and result port of the
//                feeder. slave = feeder side, master = host/SW side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sw_seq_feeder_if #(
    parameter int WIDTH_SCORE     = 8,
    parameter int WIDTH_POS_REF   = 7,
    parameter int WIDTH_POS_QUERY = 6
);

    logic                       in_valid;
    logic                       in_ready;
    logic [7:0]                 in_sym;

    logic                       sw_valid;
    logic [1:0]                 sw_data_ref;
    logic [1:0]                 sw_data_query;
    logic                       sw_finish;
    logic [WIDTH_SCORE-1:0]     sw_max;
    logic [WIDTH_POS_REF-1:0]   sw_pos_ref;
    logic [WIDTH_POS_QUERY-1:0] sw_pos_query;

    logic                       res_valid;
    logic                       res_ready;
    logic [WIDTH_SCORE-1:0]     res_max;
    logic [WIDTH_POS_REF-1:0]   res_pos_ref;
    logic [WIDTH_POS_QUERY-1:0] res_pos_query;
    logic                       res_err;
    logic [15:0]                jobs_done;

    modport slave (
        input  in_valid, in_sym,
        output in_ready,
        output sw_valid, sw_data_ref, sw_data_query,
        input  sw_finish, sw_max, sw_pos_ref, sw_pos_query,
        output res_valid, res_max, res_pos_ref, res_pos_query, res_err, jobs_done,
        input  res_ready
    );

    modport master (
        output in_valid, in_sym,
        input  in_ready,
        input  sw_valid, sw_data_ref, sw_data_query,
        output sw_finish, sw_max, sw_pos_ref, sw_pos_query,
        input  res_valid, res_max, res_pos_ref, res_pos_query, res_err, jobs_done,
        output res_ready
    );

endinterface : sw_seq_feeder_if
`default_nettype wire

// File: rtl/sw_seq_feeder_decode.sv
`default_nettype none
// ============================================================================
//  Module      : sw_sym_decode
//  Description : Host byte -> 2-bit base code plus illegal flag.
//                SW_FEED_ASCII_EN selects ASCII decoding; otherwise the low
//                two bits are the code and nothing is ever illegal.
//  Revision    : 1.0 - initial release
// ============================================================================
module sw_sym_decode
    import sw_pkg::*;
(
    input  logic [7:0] i_sym,
    output logic [1:0] o_code,
    output logic       o_illegal
);

`ifdef SW_FEED_ASCII_EN
    always_comb begin
        o_code    = c_BASE_A;
        o_illegal = 1'b0;
        case (i_sym)
            c_ASCII_A_UP, c_ASCII_A_LO: o_code = c_BASE_A;
            c_ASCII_C_UP, c_ASCII_C_LO: o_code = c_BASE_C;
            c_ASCII_G_UP, c_ASCII_G_LO: o_code = c_BASE_G;
            c_ASCII_T_UP, c_ASCII_T_LO: o_code = c_BASE_T;
            // unknown bytes store as A and flag the job
            default:                    o_illegal = 1'b1;
        endcase
    end
`else
    logic w_unused_hi;

    assign o_code      = i_sym[1:0];
    assign o_illegal   = 1'b0;
    assign w_unused_hi = ^i_sym[7:2];
`endif

endmodule : sw_sym_decode
`default_nettype wire

// File: rtl/sw_seq_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : sw_seq_feeder
//  Description : Buffers one job (ref + query) from a stalling host stream,
//                replays it to the SW array as a gapless burst, then returns
//                the SW result on a valid/ready port.
//                Build option SW_FEED_ASCII_EN: ASCII symbols + res_err.
//  Revision    : 1.0 - initial release
// ============================================================================
module sw_seq_feeder
    import sw_pkg::*;
#(
    parameter int WIDTH_SCORE     = 8,
    parameter int WIDTH_POS_REF   = 7,
    parameter int WIDTH_POS_QUERY = 6,
    parameter int LEN_REF         = c_LEN_REF,
    parameter int LEN_QUERY       = c_LEN_QUERY
)(
    input  logic             clk,
    input  logic             reset,
    sw_seq_feeder_if.slave   bus
);

    localparam int CNT_W  = $clog2(LEN_REF + LEN_QUERY);
    localparam int REF_AW = $clog2(LEN_REF);
    localparam int QRY_AW = $clog2(LEN_QUERY);

    localparam logic [CNT_W-1:0] c_LAST_BEAT = CNT_W'(LEN_REF + LEN_QUERY - 1);
    localparam logic [CNT_W-1:0] c_REF_LAST  = CNT_W'(LEN_REF - 1);
    localparam logic [CNT_W-1:0] c_REF_LEN   = CNT_W'(LEN_REF);
    localparam logic [CNT_W-1:0] c_QRY_LEN   = CNT_W'(LEN_QUERY);

    feed_state_t                r_state, w_state_nxt;
    logic [CNT_W-1:0]           r_cnt, w_cnt_nxt, w_cnt_inc;
    logic                       r_err, w_err_nxt;

    logic [1:0]                 r_ref_buf [LEN_REF];
    logic [1:0]                 r_qry_buf [LEN_QUERY];

    logic [1:0]                 w_code;
    logic                       w_illegal;
    logic                       w_in_ready;
    logic                       w_accept;

    logic [REF_AW-1:0]          w_ref_wr_idx;
    logic [QRY_AW-1:0]          w_qry_wr_idx;
    logic [CNT_W-1:0]           w_rd_idx;
    logic [1:0]                 w_rd_ref;
    logic [1:0]                 w_rd_qry;

    logic                       r_sw_valid, w_sw_valid_nxt;
    logic [1:0]                 r_sw_data_ref, w_sw_data_ref_nxt;
    logic [1:0]                 r_sw_data_query, w_sw_data_query_nxt;

    logic                       r_res_valid, w_res_valid_nxt;
    logic [WIDTH_SCORE-1:0]     r_res_max, w_res_max_nxt;
    logic [WIDTH_POS_REF-1:0]   r_res_pos_ref, w_res_pos_ref_nxt;
    logic [WIDTH_POS_QUERY-1:0] r_res_pos_query, w_res_pos_query_nxt;
    logic [15:0]                r_jobs_done, w_jobs_done_nxt;

    sw_sym_decode u_decode (
        .i_sym     (bus.in_sym),
        .o_code    (w_code),
        .o_illegal (w_illegal)
    );

    assign w_in_ready   = (r_state == ST_LOAD);
    assign w_accept     = bus.in_valid & w_in_ready;
    assign w_cnt_inc    = r_cnt + 1'b1;

    assign w_ref_wr_idx = REF_AW'(r_cnt);
    assign w_qry_wr_idx = QRY_AW'(r_cnt - c_REF_LEN);

    // Read one symbol ahead so sw_data_* can be registered with sw_valid
    assign w_rd_idx = (r_state == ST_BURST) ? w_cnt_inc : '0;
    assign w_rd_ref = r_ref_buf[REF_AW'(w_rd_idx)];
    assign w_rd_qry = (w_rd_idx < c_QRY_LEN) ? r_qry_buf[QRY_AW'(w_rd_idx)] : c_BASE_A;

    // Symbol storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (!reset && w_accept) begin
            if (r_cnt < c_REF_LEN) begin
                r_ref_buf[w_ref_wr_idx] <= w_code;
            end else begin
                r_qry_buf[w_qry_wr_idx] <= w_code;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_LOAD;
            r_cnt           <= '0;
            r_err           <= 1'b0;
            r_sw_valid      <= 1'b0;
            r_sw_data_ref   <= c_BASE_A;
            r_sw_data_query <= c_BASE_A;
            r_res_valid     <= 1'b0;
            r_res_max       <= '0;
            r_res_pos_ref   <= '0;
            r_res_pos_query <= '0;
            r_jobs_done     <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_err           <= w_err_nxt;
            r_sw_valid      <= w_sw_valid_nxt;
            r_sw_data_ref   <= w_sw_data_ref_nxt;
            r_sw_data_query <= w_sw_data_query_nxt;
            r_res_valid     <= w_res_valid_nxt;
            r_res_max       <= w_res_max_nxt;
            r_res_pos_ref   <= w_res_pos_ref_nxt;
            r_res_pos_query <= w_res_pos_query_nxt;
            r_jobs_done     <= w_jobs_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_cnt_nxt           = r_cnt;
        w_err_nxt           = r_err;
        w_sw_valid_nxt      = 1'b0;
        w_sw_data_ref_nxt   = c_BASE_A;
        w_sw_data_query_nxt = c_BASE_A;
        w_res_valid_nxt     = r_res_valid;
        w_res_max_nxt       = r_res_max;
        w_res_pos_ref_nxt   = r_res_pos_ref;
        w_res_pos_query_nxt = r_res_pos_query;
        w_jobs_done_nxt     = r_jobs_done;

        case (r_state)
            ST_LOAD: begin
                if (w_accept) begin
                    w_err_nxt = r_err | w_illegal;
                    if (r_cnt == c_LAST_BEAT) begin
                        // first burst beat leaves on the very next cycle
                        w_state_nxt         = ST_BURST;
                        w_cnt_nxt           = '0;
                        w_sw_valid_nxt      = 1'b1;
                        w_sw_data_ref_nxt   = w_rd_ref;
                        w_sw_data_query_nxt = w_rd_qry;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end

            ST_BURST: begin
                if (r_cnt == c_REF_LAST) begin
                    w_state_nxt = ST_WAIT_FIN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt           = w_cnt_inc;
                    w_sw_valid_nxt      = 1'b1;
                    w_sw_data_ref_nxt   = w_rd_ref;
                    w_sw_data_query_nxt = w_rd_qry;
                end
            end

            ST_WAIT_FIN: begin
                if (bus.sw_finish) begin
                    w_state_nxt         = ST_RESULT;
                    w_res_valid_nxt     = 1'b1;
                    w_res_max_nxt       = bus.sw_max;
                    w_res_pos_ref_nxt   = bus.sw_pos_ref;
                    w_res_pos_query_nxt = bus.sw_pos_query;
                end
            end

            ST_RESULT: begin
                if (bus.res_ready) begin
                    w_state_nxt     = ST_LOAD;
                    w_res_valid_nxt = 1'b0;
                    w_err_nxt       = 1'b0;
                    w_cnt_nxt       = '0;
                    w_jobs_done_nxt = r_jobs_done + 16'd1;
                end
            end

            default: begin
                w_state_nxt = ST_LOAD;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.sw_valid      = r_sw_valid;
    assign bus.sw_data_ref   = r_sw_data_ref;
    assign bus.sw_data_query = r_sw_data_query;
    assign bus.res_valid     = r_res_valid;
    assign bus.res_max       = r_res_max;
    assign bus.res_pos_ref   = r_res_pos_ref;
    assign bus.res_pos_query = r_res_pos_query;
    assign bus.jobs_done     = r_jobs_done;

`ifdef SW_FEED_ASCII_EN
    assign bus.res_err = r_err;
`else
    logic w_unused_err;

    assign w_unused_err = r_err;
    assign bus.res_err  = 1'b0;
`endif

endmodule : sw_seq_feeder
`default_nettype wire
